// File: rtl/recipe_seq_pkg.sv
// Shared types and widths for the recipe sequencer.
// The rinse states are built only when RECIPE_SEQ_RINSE_EN is defined.
// Without that macro their encodings are reserved and never entered.
package recipe_seq_pkg;

    localparam int STATE_W = 4;   // width of the encoded state output
    localparam int WD_W    = 16;  // watchdog counter width
    localparam int CNT_W   = 16;  // dose / mix / pan counter width

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE        = 4'd0,
        ST_FILL        = 4'd1,
        ST_FLOUR       = 4'd2,
        ST_SALT        = 4'd3,
        ST_CLOSE       = 4'd4,
        ST_MIX         = 4'd5,
        ST_OPEN        = 4'd6,
        ST_DISPENSE    = 4'd7,
        ST_DRAIN       = 4'd8,
        ST_RINSE_FILL  = 4'd9,
        ST_RINSE_MIX   = 4'd10,
        ST_RINSE_DRAIN = 4'd11,
        ST_DONE        = 4'd12,
        ST_FAULT       = 4'd13
    } seq_state_t;

    // A batch is in progress everywhere except the two resting states
    function automatic logic is_busy(input seq_state_t s);
        return !((s == ST_IDLE) || (s == ST_FAULT));
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Per-state watchdog: counts enabled cycles since the last reload and
// flags expiry on the cycle whose enabled edge would be the TIMEOUT-th.
// RECIPE_SEQ_RINSE_EN has no effect on this block.
module seq_watchdog
    import recipe_seq_pkg::*;
#(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic reload,
    output logic expired
);

    localparam logic [WD_W-1:0] LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] cnt_reg;

    assign expired = (cnt_reg >= LAST);

    // Count enabled cycles in the current state; saturate once expired
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (en) begin
            if (reload) begin
                cnt_reg <= '0;
            end else if (!expired) begin
                cnt_reg <= cnt_reg + WD_W'(1);
            end
        end
    end

endmodule

// File: rtl/recipe_sequencer.sv
// Batch sequencer for a dough plant: fill, dose flour and salt, knead
// under pressure, dispense into pans, drain (and optionally rinse).
// Optional rinse cycle is enabled by defining RECIPE_SEQ_RINSE_EN.
module recipe_sequencer
    import recipe_seq_pkg::*;
#(
    parameter int          FLOUR_UNITS   = 4,
    parameter int          SALT_UNITS    = 2,
    parameter int          MIX_CYCLES    = 64,
    parameter logic [15:0] PRESSURE_SET  = 16'h0800,
    parameter int          DISPENSE_PANS = 4,
    parameter int          TIMEOUT       = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        start,
    input  logic        abort,
    input  logic        Y_flour,
    input  logic        Y_salt,
    input  logic        Y_flour_remain,
    input  logic        Y_salt_remain,
    input  logic        Y_water_base,
    input  logic        Y_water_middle,
    input  logic        Y_water_top,
    input  logic        S_cover_closed,
    input  logic        S_cover_opened,
    input  logic [15:0] S_pressure,
    input  logic        Y_pan,
    input  logic        Y_pan_full,
    output logic        X_water,
    output logic        X_drain,
    output logic        X_flour,
    output logic        X_salt,
    output logic        X_mixer,
    output logic        X_cover,
    output logic        X_pressurize,
    output logic        X_dispenser,
    output logic        X_pan_conveyor,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [3:0]  state,
    output logic [3:0]  pans_done
);

    localparam logic [CNT_W-1:0] FLOUR_LAST = CNT_W'(FLOUR_UNITS - 1);
    localparam logic [CNT_W-1:0] SALT_LAST  = CNT_W'(SALT_UNITS - 1);
    localparam logic [CNT_W-1:0] MIX_LAST   = CNT_W'(MIX_CYCLES - 1);
    localparam logic [CNT_W-1:0] PANS_LAST  = CNT_W'(DISPENSE_PANS - 1);

    seq_state_t       state_reg, state_next;
    logic [CNT_W-1:0] unit_reg, unit_next;       // doses, mix cycles or pans in this state
    logic             filling_reg, filling_next; // a pan is under the dispenser
    logic             aborting_reg, aborting_next;
    logic [3:0]       pans_reg, pans_next;

    logic wd_reload, wd_expired;
    logic flour_done, salt_done, mix_done, unit_step;

    // Last-unit detection; these also shut the actuator off in the transition cycle
    assign flour_done = (state_reg == ST_FLOUR) && Y_flour && (unit_reg == FLOUR_LAST);
    assign salt_done  = (state_reg == ST_SALT)  && Y_salt  && (unit_reg == SALT_LAST);
    assign mix_done   = ((state_reg == ST_MIX) || (state_reg == ST_RINSE_MIX))
                        && (unit_reg == MIX_LAST);

    // Any state change restarts the watchdog
    assign wd_reload = (state_next != state_reg);

    seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .reload  (wd_reload),
        .expired (wd_expired)
    );

    // Which event advances the shared unit counter in the current state
    always_comb begin
        unit_step = 1'b0;
        case (state_reg)
            ST_FLOUR:                 unit_step = Y_flour;
            ST_SALT:                  unit_step = Y_salt;
            ST_MIX, ST_RINSE_MIX:     unit_step = 1'b1;
            ST_DISPENSE:              unit_step = filling_reg && Y_pan_full;
            default:                  unit_step = 1'b0;
        endcase
    end

    // Next-state logic; abort and watchdog expiry override the normal flow
    always_comb begin
        state_next    = state_reg;
        unit_next     = unit_reg;
        filling_next  = filling_reg;
        aborting_next = aborting_reg;
        pans_next     = pans_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next    = ST_FILL;
                    pans_next     = 4'd0;
                    aborting_next = 1'b0;
                end
            end
            ST_FILL:  if (Y_water_middle) state_next = ST_FLOUR;
            ST_FLOUR: begin
                if (flour_done)           state_next = ST_SALT;
                else if (!Y_flour_remain) state_next = ST_FAULT;
            end
            ST_SALT: begin
                if (salt_done)            state_next = ST_CLOSE;
                else if (!Y_salt_remain)  state_next = ST_FAULT;
            end
            ST_CLOSE: if (S_cover_closed) state_next = ST_MIX;
            ST_MIX:   if (mix_done)       state_next = ST_OPEN;
            ST_OPEN:  if (S_cover_opened) state_next = ST_DISPENSE;
            ST_DISPENSE: begin
                if (!filling_reg) begin
                    if (Y_pan) filling_next = 1'b1;
                end else if (Y_pan_full) begin
                    filling_next = 1'b0;
                    if (pans_reg != 4'hF) pans_next = pans_reg + 4'd1;
                    if (unit_reg == PANS_LAST) state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!Y_water_base) begin
                    if (aborting_reg) state_next = ST_IDLE;
`ifdef RECIPE_SEQ_RINSE_EN
                    else              state_next = ST_RINSE_FILL;
`else
                    else              state_next = ST_DONE;
`endif
                end
            end
`ifdef RECIPE_SEQ_RINSE_EN
            ST_RINSE_FILL:  if (Y_water_middle) state_next = ST_RINSE_MIX;
            ST_RINSE_MIX:   if (mix_done)       state_next = ST_RINSE_DRAIN;
            ST_RINSE_DRAIN: if (!Y_water_base)  state_next = ST_DONE;
`endif
            ST_DONE:  state_next = ST_IDLE;
            ST_FAULT: state_next = ST_FAULT;
            default:  state_next = ST_FAULT;   // unused encodings are treated as a fault
        endcase

        // Abort drains the bowl and returns to IDLE with no rinse and no done
        if (abort && is_busy(state_reg)) begin
            aborting_next = 1'b1;
            if (state_reg != ST_DRAIN)  state_next = ST_DRAIN;
            else if (!Y_water_base)     state_next = ST_IDLE;
        end

        // A state that stalls too long is a plant failure
        if (wd_expired && (state_reg != ST_IDLE) && (state_reg != ST_DONE)
                && (state_reg != ST_FAULT)) begin
            state_next = ST_FAULT;
        end

        if (state_next != state_reg) begin
            unit_next    = '0;
            filling_next = 1'b0;
        end else if (unit_step) begin
            unit_next = unit_reg + CNT_W'(1);
        end
    end

    // State and counters advance only on enabled cycles; reset always acts
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            unit_reg     <= '0;
            filling_reg  <= 1'b0;
            aborting_reg <= 1'b0;
            pans_reg     <= 4'd0;
        end else if (en) begin
            state_reg    <= state_next;
            unit_reg     <= unit_next;
            filling_reg  <= filling_next;
            aborting_reg <= aborting_next;
            pans_reg     <= pans_next;
        end
    end

    // Actuator decode; water-top cutoff and last-unit shutoff are combinational
    always_comb begin
        X_water        = 1'b0;
        X_drain        = 1'b0;
        X_flour        = 1'b0;
        X_salt         = 1'b0;
        X_mixer        = 1'b0;
        X_cover        = 1'b0;
        X_pressurize   = 1'b0;
        X_dispenser    = 1'b0;
        X_pan_conveyor = 1'b0;
        case (state_reg)
            ST_FILL, ST_RINSE_FILL: X_water = !Y_water_top;
            ST_FLOUR:               X_flour = !(en && flour_done);
            ST_SALT:                X_salt  = !(en && salt_done);
            ST_CLOSE:               X_cover = 1'b1;
            ST_MIX: begin
                X_cover      = 1'b1;
                X_mixer      = 1'b1;
                X_pressurize = (S_pressure < PRESSURE_SET) && !(en && mix_done);
            end
            ST_RINSE_MIX:           X_mixer = 1'b1;
            ST_DISPENSE: begin
                X_dispenser    = filling_reg;
                X_pan_conveyor = !filling_reg;
            end
            ST_DRAIN, ST_RINSE_DRAIN, ST_FAULT: X_drain = 1'b1;
            default: ;
        endcase
    end

    assign busy      = is_busy(state_reg);
    assign done      = (state_reg == ST_DONE);
    assign fault     = (state_reg == ST_FAULT);
    assign state     = state_reg;
    assign pans_done = pans_reg;

endmodule

// File: tb/tb_recipe_sequencer.sv
// Directed-with-random-timing bench for recipe_sequencer. Plant sensors respond
// after random delays; expectations come from the batch recipe, not the RTL.
// Honours RECIPE_SEQ_RINSE_EN when the bundle is built with it.
module tb_recipe_sequencer;

    localparam int FLOUR_UNITS   = 4;
    localparam int SALT_UNITS    = 2;
    localparam int MIX_CYCLES    = 64;
    localparam int DISPENSE_PANS = 4;
    localparam int TIMEOUT       = 4096;

    // State codes in the order the recipe lists them
    localparam logic [3:0] S_IDLE = 4'd0, S_FILL = 4'd1, S_FLOUR = 4'd2, S_SALT = 4'd3,
        S_CLOSE = 4'd4, S_MIX = 4'd5, S_OPEN = 4'd6, S_DISPENSE = 4'd7, S_DRAIN = 4'd8,
        S_RFILL = 4'd9, S_RMIX = 4'd10, S_RDRAIN = 4'd11, S_DONE = 4'd12, S_FAULT = 4'd13;

    // Actuator vector {water,drain,flour,salt,mixer,cover,press,disp,conv}
    localparam logic [8:0] XV_NONE = 9'b000000000, XV_WATER = 9'b100000000,
        XV_DRAIN = 9'b010000000, XV_FLOUR = 9'b001000000, XV_SALT = 9'b000100000,
        XV_MIXER = 9'b000010000, XV_COVER = 9'b000001000, XV_DISP = 9'b000000010,
        XV_CONV = 9'b000000001;

    logic clk = 1'b0;
    logic rst, en, start, abort;
    logic Y_flour, Y_salt, Y_flour_remain, Y_salt_remain;
    logic Y_water_base, Y_water_middle, Y_water_top;
    logic S_cover_closed, S_cover_opened;
    logic [15:0] S_pressure;
    logic Y_pan, Y_pan_full;
    logic X_water, X_drain, X_flour, X_salt, X_mixer, X_cover, X_pressurize;
    logic X_dispenser, X_pan_conveyor, busy, done, fault;
    logic [3:0] state, pans_done;
    logic [8:0] xv;

    int checks = 0, errors = 0;
    int en_cnt = 0, done_cnt = 0, rinse_seen = 0;
    bit gate_mode = 1'b0;

    assign xv = {X_water, X_drain, X_flour, X_salt, X_mixer, X_cover, X_pressurize,
                 X_dispenser, X_pan_conveyor};

    always #5 clk = ~clk;

    recipe_sequencer #(
        .FLOUR_UNITS(FLOUR_UNITS), .SALT_UNITS(SALT_UNITS), .MIX_CYCLES(MIX_CYCLES),
        .PRESSURE_SET(16'h0800), .DISPENSE_PANS(DISPENSE_PANS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .abort(abort),
        .Y_flour(Y_flour), .Y_salt(Y_salt), .Y_flour_remain(Y_flour_remain),
        .Y_salt_remain(Y_salt_remain), .Y_water_base(Y_water_base),
        .Y_water_middle(Y_water_middle), .Y_water_top(Y_water_top),
        .S_cover_closed(S_cover_closed), .S_cover_opened(S_cover_opened),
        .S_pressure(S_pressure), .Y_pan(Y_pan), .Y_pan_full(Y_pan_full),
        .X_water(X_water), .X_drain(X_drain), .X_flour(X_flour), .X_salt(X_salt),
        .X_mixer(X_mixer), .X_cover(X_cover), .X_pressurize(X_pressurize),
        .X_dispenser(X_dispenser), .X_pan_conveyor(X_pan_conveyor),
        .busy(busy), .done(done), .fault(fault), .state(state), .pans_done(pans_done)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end else begin
            $display("PASS %s: %0h", tag, obs);
        end
    endtask

    // One clock; en is random in gated mode unless the caller needs the edge to count
    task automatic step(input bit force_en);
        logic [3:0] prev;
        if (force_en || !gate_mode) en = 1'b1;
        else en = 1'($urandom_range(0, 1));
        prev = state;
        if (en && done && !rst) done_cnt++;
        @(posedge clk);
        #1;
        if (en) en_cnt++;
        if (!en && !rst) chk("hold_on_en0", state, prev);
        chk("water_and_drain", X_water & X_drain, 1'b0);
        chk("flour_and_salt", X_flour & X_salt, 1'b0);
`ifndef RECIPE_SEQ_RINSE_EN
        if (state == S_RFILL || state == S_RMIX || state == S_RDRAIN) rinse_seen++;
`endif
    endtask

    task automatic gaps();
        repeat ($urandom_range(0, 3)) step(1'b0);
    endtask

    task automatic t_start();
        start = 1'b1;
        step(1'b1);
        start = 1'b0;
        chk("start_state", state, S_FILL);
        chk("start_busy", busy, 1'b1);
        chk("start_pans_clear", pans_done, 4'd0);
        chk("fill_outputs", xv, XV_WATER);
        Y_water_top = 1'b1;
        #1;
        chk("water_top_cutoff", X_water, 1'b0);
        Y_water_top = 1'b0;
    endtask

    task automatic t_fill();
        Y_water_base = 1'b1;
        gaps();
        Y_water_middle = 1'b1;
        step(1'b1);
        Y_water_middle = 1'b0;
        chk("fill_to_flour", state, S_FLOUR);
        chk("flour_outputs", xv, XV_FLOUR);
    endtask

    // n dose pulses out of a batch total; the completing pulse must cut the feeder
    task automatic t_doses(input bit salt, input int n, input int total);
        for (int i = 0; i < n; i++) begin
            gaps();
            if (salt) Y_salt = 1'b1; else Y_flour = 1'b1;
            en = 1'b1;
            #1;
            if (i == total - 1) chk("dose_last_off", salt ? X_salt : X_flour, 1'b0);
            else                chk("dose_on", salt ? X_salt : X_flour, 1'b1);
            step(1'b1);
            Y_flour = 1'b0;
            Y_salt  = 1'b0;
        end
    endtask

    task automatic t_to_close();
        t_start();
        t_fill();
        t_doses(1'b0, FLOUR_UNITS, FLOUR_UNITS);
        chk("flour_to_salt", state, S_SALT);
        chk("salt_outputs", xv, XV_SALT);
        t_doses(1'b1, SALT_UNITS, SALT_UNITS);
        chk("salt_to_close", state, S_CLOSE);
        chk("close_outputs", xv, XV_COVER);
    endtask

    task automatic t_enter_mix();
        gaps();
        S_cover_closed = 1'b1;
        step(1'b1);
        S_cover_closed = 1'b0;
        chk("close_to_mix", state, S_MIX);
        chk("mix_mixer", X_mixer, 1'b1);
        chk("mix_cover", X_cover, 1'b1);
    endtask

    // Kneading lasts MIX_CYCLES enabled cycles; pressure below set point pressurizes
    task automatic t_mix();
        int en_at;
        logic [15:0] p;
        en_at = en_cnt;
        S_pressure = 16'h07FF;
        #1;
        chk("press_below_set", X_pressurize, 1'b1);
        S_pressure = 16'h0800;
        #1;
        chk("press_at_set", X_pressurize, 1'b0);
        p = 16'($urandom_range(0, 16'hFFFF));
        S_pressure = p;
        #1;
        chk("press_random", X_pressurize, (p < 16'h0800));
        for (int k = 0; k < 2000 && (en_cnt - en_at) < MIX_CYCLES - 1; k++) step(1'b0);
        chk("mix_still_running", state, S_MIX);
        S_pressure = 16'h0000;
        en = 1'b1;
        #1;
        chk("press_off_at_end", X_pressurize, 1'b0);
        step(1'b1);
        chk("mix_to_open", state, S_OPEN);
        chk("open_outputs", xv, XV_NONE);
    endtask

    task automatic t_open();
        gaps();
        S_cover_opened = 1'b1;
        step(1'b1);
        S_cover_opened = 1'b0;
        chk("open_to_dispense", state, S_DISPENSE);
        chk("conveyor_on", xv, XV_CONV);
    endtask

    task automatic t_one_pan(input int i);
        gaps();
        Y_pan = 1'b1;
        step(1'b1);
        Y_pan = 1'b0;
        chk("dispenser_on", xv, XV_DISP);
        gaps();
        Y_pan_full = 1'b1;
        step(1'b1);
        Y_pan_full = 1'b0;
        chk("pans_count", pans_done, i + 1);
    endtask

    task automatic t_dispense();
        for (int i = 0; i < DISPENSE_PANS; i++) begin
            t_one_pan(i);
            if (i < DISPENSE_PANS - 1) chk("conveyor_resumes", xv, XV_CONV);
        end
        chk("dispense_to_drain", state, S_DRAIN);
        chk("drain_outputs", xv, XV_DRAIN);
    endtask

    task automatic t_finish_batch();
        gaps();
        Y_water_base = 1'b0;
        step(1'b1);
`ifdef RECIPE_SEQ_RINSE_EN
        begin
            int en_at;
            chk("drain_to_rinse", state, S_RFILL);
            chk("rinse_fill_outputs", xv, XV_WATER);
            Y_water_base = 1'b1;
            gaps();
            Y_water_middle = 1'b1;
            step(1'b1);
            Y_water_middle = 1'b0;
            chk("rinse_mix", state, S_RMIX);
            chk("rinse_mix_outputs", xv, XV_MIXER);
            en_at = en_cnt;
            for (int k = 0; k < 2000 && (en_cnt - en_at) < MIX_CYCLES; k++) step(1'b0);
            chk("rinse_drain", state, S_RDRAIN);
            chk("rinse_drain_outputs", xv, XV_DRAIN);
            gaps();
            Y_water_base = 1'b0;
            step(1'b1);
        end
`endif
        chk("to_done", state, S_DONE);
        chk("done_pulse", done, 1'b1);
        for (int k = 0; k < 20 && state != S_IDLE; k++) step(1'b0);
        chk("done_to_idle", state, S_IDLE);
        chk("done_low_in_idle", done, 1'b0);
    endtask

    task automatic run_batch(input bit gm);
        int d0;
        gate_mode = gm;
        d0 = done_cnt;
        t_to_close();
        t_enter_mix();
        t_mix();
        t_open();
        t_dispense();
        t_finish_batch();
        chk("batch_done_once", done_cnt - d0, 1);
        chk("batch_pans", pans_done, DISPENSE_PANS);
        chk("batch_no_fault", fault, 1'b0);
        chk("batch_not_busy", busy, 1'b0);
        gate_mode = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b1);
        rst = 1'b0;
    endtask

    task automatic chk_reset_values();
        chk("rst_state", state, S_IDLE);
        chk("rst_outputs", xv, XV_NONE);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_fault", fault, 1'b0);
        chk("rst_pans", pans_done, 4'd0);
    endtask

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        rst = 1'b1; en = 1'b1; start = 1'b0; abort = 1'b0;
        Y_flour = 1'b0; Y_salt = 1'b0; Y_flour_remain = 1'b1; Y_salt_remain = 1'b1;
        Y_water_base = 1'b0; Y_water_middle = 1'b0; Y_water_top = 1'b0;
        S_cover_closed = 1'b0; S_cover_opened = 1'b0; S_pressure = 16'h0000;
        Y_pan = 1'b0; Y_pan_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_values();
        checks++;
        if (state !== S_IDLE) begin
            errors++;
            $error("FAIL init_idle: observed %0h required %0h", state, S_IDLE);
        end

        // Nominal batch, then the same batch with en toggling throughout
        run_batch(1'b0);
        checks++;
        if (pans_done !== 4'(DISPENSE_PANS)) begin
            errors++;
            $error("FAIL nominal_pans: observed %0h required %0h", pans_done, DISPENSE_PANS);
        end
        run_batch(1'b1);
        checks++;
        if (state !== S_IDLE) begin
            errors++;
            $error("FAIL gated_idle: observed %0h required %0h", state, S_IDLE);
        end

        // start beats abort in IDLE; abort in FILL drains straight back to IDLE
        d0 = done_cnt;
        start = 1'b1; abort = 1'b1;
        step(1'b1);
        start = 1'b0; abort = 1'b0;
        chk("start_wins", state, S_FILL);
        abort = 1'b1;
        step(1'b1);
        abort = 1'b0;
        chk("abort_fill_drain", state, S_DRAIN);
        step(1'b1);
        chk("abort_fill_idle", state, S_IDLE);

        // Abort after ten kneading cycles
        t_to_close();
        t_enter_mix();
        repeat (10) step(1'b1);
        abort = 1'b1;
        step(1'b1);
        abort = 1'b0;
        chk("abort_mix_drain", state, S_DRAIN);
        chk("abort_drain_outputs", xv, XV_DRAIN);
        step(1'b1);
        chk("abort_waits_for_base", state, S_DRAIN);
        Y_water_base = 1'b0;
        step(1'b1);
        chk("abort_to_idle", state, S_IDLE);
        chk("abort_no_done", done_cnt - d0, 0);
        checks++;
        if (done_cnt !== d0) begin
            errors++;
            $error("FAIL abort_done_count: observed %0d required %0d", done_cnt, d0);
        end

        // Flour hopper runs empty after two doses
        t_start();
        t_fill();
        t_doses(1'b0, 2, FLOUR_UNITS);
        Y_flour_remain = 1'b0;
        step(1'b1);
        Y_flour_remain = 1'b1;
        chk("hopper_fault_state", state, S_FAULT);
        chk("hopper_fault_flag", fault, 1'b1);
        chk("hopper_fault_outputs", xv, XV_DRAIN);
        chk("hopper_not_busy", busy, 1'b0);
        start = 1'b1; abort = 1'b1;
        step(1'b1);
        start = 1'b0; abort = 1'b0;
        chk("fault_sticky", state, S_FAULT);
        checks++;
        if (fault !== 1'b1) begin
            errors++;
            $error("FAIL fault_flag_sticky: observed %0h required 1", fault);
        end
        do_reset();
        chk_reset_values();

        // Cover never reports closed: fault after exactly TIMEOUT enabled cycles
        t_to_close();
        repeat (TIMEOUT - 1) step(1'b1);
        chk("wd_before_timeout", state, S_CLOSE);
        step(1'b1);
        chk("wd_fault", state, S_FAULT);
        chk("wd_fault_outputs", xv, XV_DRAIN);
        checks++;
        if (xv !== XV_DRAIN) begin
            errors++;
            $error("FAIL wd_xv: observed %0h required %0h", xv, XV_DRAIN);
        end
        do_reset();

        // Reset with en low in the middle of dispensing
        t_to_close();
        t_enter_mix();
        t_mix();
        t_open();
        t_one_pan(0);
        rst = 1'b1;
        en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_values();
        checks++;
        if (xv !== XV_NONE) begin
            errors++;
            $error("FAIL rst_mid_xv: observed %0h required %0h", xv, XV_NONE);
        end

`ifndef RECIPE_SEQ_RINSE_EN
        chk("rinse_never_seen", rinse_seen, 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/recipe_sequencer.md
RECIPE_SEQUENCER -- requirements
Module: recipe_sequencer

Interface
REQ-001 Parameters SHALL be: FLOUR_UNITS (default 4), flour doses per batch; SALT_UNITS (default 2), salt doses per batch; MIX_CYCLES (default 64), kneading time; PRESSURE_SET (default 16'h0800), pressurize target; DISPENSE_PANS (default 4), pans filled per batch; TIMEOUT (default 4096), per-state watchdog in cycles.
REQ-002 Ports SHALL be, in order: clk in 1 (sole clock); rst in 1 (synchronous, active-high reset); en in 1 (plant tick enable); start in 1 (begin batch); abort in 1 (cancel batch).
REQ-003 Sensor inputs SHALL be: Y_flour, Y_salt in 1 (one-cycle unit-delivered pulses); Y_flour_remain, Y_salt_remain in 1 (hopper not empty); Y_water_base, Y_water_middle, Y_water_top in 1 (level probes); S_cover_closed, S_cover_opened in 1; S_pressure in 16; Y_pan, Y_pan_full in 1 (pan present, pan full).
REQ-004 Command outputs SHALL be: X_water, X_drain, X_flour, X_salt, X_mixer, X_cover, X_pressurize, X_dispenser, X_pan_conveyor, all out 1.
REQ-005 Status outputs SHALL be: busy out 1; done out 1 (one-cycle pulse); fault out 1 (sticky); state out 4 (encoded FSM state); pans_done out 4.

Function
REQ-006 State, counters and outputs SHALL update only on clk edges with en=1; with en=0 everything SHALL hold, except that rst always acts.
REQ-007 FSM states SHALL be IDLE, FILL, FLOUR, SALT, CLOSE, MIX, OPEN, DISPENSE, DRAIN, RINSE_FILL, RINSE_MIX, RINSE_DRAIN, DONE, FAULT.
REQ-008 IDLE: start=1 -> FILL; busy=0 only in IDLE and FAULT.
REQ-009 FILL: X_water=1 until Y_water_middle=1 -> FLOUR; Y_water_top=1 in any state -> X_water=0 in the same cycle, combinationally.
REQ-010 FLOUR: X_flour=1; each Y_flour pulse increments a unit counter; at FLOUR_UNITS -> SALT, with X_flour=0 in the transition cycle. SALT behaves the same with X_salt, Y_salt and SALT_UNITS -> CLOSE.
REQ-011 Y_flour_remain=0 in FLOUR, or Y_salt_remain=0 in SALT, before the count completes -> FAULT.
REQ-012 CLOSE: X_cover=1 (cover closing) until S_cover_closed -> MIX; X_cover SHALL stay 1 through MIX.
REQ-013 MIX: X_mixer=1; X_pressurize=1 while S_pressure < PRESSURE_SET (unsigned compare); after MIX_CYCLES cycles -> OPEN with X_pressurize=0.
REQ-014 OPEN: X_cover=0 until S_cover_opened -> DISPENSE.
REQ-015 DISPENSE: X_pan_conveyor=1 until Y_pan, then X_dispenser=1 until Y_pan_full. Each pan-full event increments pans_done (saturating at 15), then the conveyor resumes. At DISPENSE_PANS -> DRAIN.
REQ-016 DRAIN: X_drain=1 until Y_water_base=0 -> RINSE_FILL. RINSE_FILL: X_water until Y_water_middle -> RINSE_MIX. RINSE_MIX: X_mixer for MIX_CYCLES -> RINSE_DRAIN. RINSE_DRAIN: X_drain until Y_water_base=0 -> DONE.
REQ-017 DONE SHALL assert done for one en-cycle and then go to IDLE; pans_done holds until the next start.
REQ-018 A watchdog SHALL reload on every state change; reaching TIMEOUT in any state other than IDLE, DONE or FAULT -> FAULT.
REQ-019 FAULT SHALL drive all X_* to 0 except X_drain=1 and set fault=1; it exits only by rst.
REQ-020 abort=1 in any busy state SHALL force the FSM to DRAIN and then go to IDLE, without rinse and without a done pulse. abort in IDLE or FAULT SHALL be ignored. If abort and start are both asserted in IDLE, start wins.
REQ-021 X_water and X_drain SHALL never both be 1, and X_flour and X_salt SHALL never both be 1.

Reset
REQ-022 rst SHALL force IDLE, all X_*=0, busy=0, done=0, fault=0, pans_done=0, and clear all counters, including when asserted mid-batch or while en=0.

Configuration
REQ-023 Macro RECIPE_SEQ_RINSE_EN: when defined, the rinse states exist as in REQ-016. When undefined, DRAIN goes directly to DONE, the RINSE_* encodings are unused, and MIX timing is unchanged.

Structure
REQ-024 Package recipe_seq_pkg SHALL hold the state enum, a 4-bit state width constant and the watchdog width.
REQ-025 The watchdog SHALL be a sub-module seq_watchdog (clk, rst, en, reload, expired), parameterized by TIMEOUT.

Verification
REQ-026 Nominal batch with defaults: start; 4 Y_flour pulses, 2 Y_salt pulses, 4 pans -> one done pulse, pans_done=4, state returns to IDLE, fault=0.
REQ-027 Hopper empty: Y_flour_remain=0 after 2 flour pulses -> FAULT, fault=1, X_drain=1, all other X_*=0.
REQ-028 Abort during MIX at cycle 10 -> next state DRAIN; Y_water_base=0 -> IDLE; no done pulse.
REQ-029 Watchdog: S_cover_closed held 0 in CLOSE -> FAULT exactly TIMEOUT en-cycles after entering CLOSE.
REQ-030 en gating: en toggled 1/0 throughout a batch -> same output sequence as the nominal batch, stretched, with no state change on en=0 cycles; rst during DISPENSE -> all outputs at reset values next cycle.
REQ-031 Build without RECIPE_SEQ_RINSE_EN -> DRAIN followed directly by DONE; RINSE_* never observed on state.
